// File: rtl/pdm_serializer_if.sv
// rtl/pdm_serializer_if.sv - PCM sample valid/ready handshake bundle
interface pdm_serializer_if #(
   parameter int WIDTH = 16
) ();
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );
endinterface

// File: rtl/pdm_serializer.sv
// rtl/pdm_serializer.sv - PCM to 1-bit PDM first-order sigma-delta serializer
// One-deep input buffer feeds the current sample; the accumulator carry is the PDM bit.
module pdm_serializer #(
   parameter int CLK_DIV         = 100,
   parameter int WIDTH           = 16,
   parameter int BITS_PER_SAMPLE = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   pdm_serializer_if.slave  s_if,
   output logic             pdm_o,
   output logic             pdm_clk_o,
   output logic             audio_sd_o,
   output logic             underrun,
   output logic             busy
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (BITS_PER_SAMPLE > 1) ? $clog2(BITS_PER_SAMPLE) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_SAMPLE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic             buf_full_q, buf_full_d;
   logic [WIDTH-1:0] cur_q, cur_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
   logic             pdm_q, pdm_d;
   logic             pdm_clk_q, pdm_clk_d;
   logic             sd_q, sd_d;
   logic             busy_q, busy_d;
   logic             underrun_q, underrun_d;

   logic             ready;
   logic             accept;
   logic             tick;
   logic [WIDTH:0]   sum;

   // The handshake is gated only by enable, so a sample can be taken while still in IDLE.
   assign ready  = enable && !buf_full_q;
   assign accept = s_if.valid && ready;
   assign tick   = (div_q == DIV_LAST);
   assign sum    = {1'b0, acc_q} + {1'b0, cur_q};

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      cur_d      = cur_q;
      acc_d      = acc_q;
      div_d      = div_q;
      bitcnt_d   = bitcnt_q;
      pdm_d      = pdm_q;
      underrun_d = 1'b0;

      if (!enable) begin
         state_d    = IDLE;
         buf_d      = '0;
         buf_full_d = 1'b0;
         cur_d      = '0;
         acc_d      = '0;
         div_d      = '0;
         bitcnt_d   = '0;
         pdm_d      = 1'b0;
      end else begin
         // accept and a buffer drain are exclusive: accept needs an empty buffer
         if (accept) begin
            buf_d      = s_if.data;
            buf_full_d = 1'b1;
         end
         case (state_q)
            IDLE: begin
               state_d = PRIME;
            end
            PRIME: begin
               if (buf_full_q) begin
                  cur_d      = buf_q;
                  buf_full_d = 1'b0;
                  div_d      = '0;
                  bitcnt_d   = '0;
                  acc_d      = '0;
                  state_d    = RUN;
               end
            end
            RUN: begin
               div_d = tick ? '0 : div_q + DIV_W'(1);
               if (tick) begin
                  acc_d = sum[WIDTH-1:0];
                  pdm_d = sum[WIDTH];
                  if (bitcnt_q == BIT_LAST) begin
                     bitcnt_d = '0;
                     // On an empty buffer the last sample repeats and acc runs on.
                     if (buf_full_q) begin
                        cur_d      = buf_q;
                        buf_full_d = 1'b0;
                     end else begin
                        underrun_d = 1'b1;
                     end
                  end else begin
                     bitcnt_d = bitcnt_q + BIT_W'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      pdm_clk_d = (state_d == RUN) && (div_d < DIV_HALF);
      sd_d      = (state_d != IDLE);
      busy_d    = (state_d == RUN);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         cur_q      <= '0;
         acc_q      <= '0;
         div_q      <= '0;
         bitcnt_q   <= '0;
         pdm_q      <= 1'b0;
         pdm_clk_q  <= 1'b0;
         sd_q       <= 1'b0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         cur_q      <= cur_d;
         acc_q      <= acc_d;
         div_q      <= div_d;
         bitcnt_q   <= bitcnt_d;
         pdm_q      <= pdm_d;
         pdm_clk_q  <= pdm_clk_d;
         sd_q       <= sd_d;
         busy_q     <= busy_d;
         underrun_q <= underrun_d;
      end
   end

   assign s_if.ready = ready;
   assign pdm_o      = pdm_q;
   assign pdm_clk_o  = pdm_clk_q;
   assign audio_sd_o = sd_q;
   assign busy       = busy_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_pdm_serializer.sv
// tb/tb_pdm_serializer.sv - randomized bench for pdm_serializer against a cumulative-sum model
module tb_pdm_serializer;
   localparam int CLK_DIV = 4;
   localparam int WIDTH   = 16;
   localparam int BPS     = 16;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic enable  = 1'b0;
   logic pdm_o, pdm_clk_o, audio_sd_o, underrun, busy;

   pdm_serializer_if #(.WIDTH(WIDTH)) s_if ();

   pdm_serializer #(
      .CLK_DIV         (CLK_DIV),
      .WIDTH           (WIDTH),
      .BITS_PER_SAMPLE (BPS)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (enable),
      .s_if       (s_if),
      .pdm_o      (pdm_o),
      .pdm_clk_o  (pdm_clk_o),
      .audio_sd_o (audio_sd_o),
      .underrun   (underrun),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: mode 0=idle 1=prime 2=run; m_t counts run cycles, m_total is the running
   // sum of every sample value played so far, so each PDM bit is a carry out of 2^WIDTH.
   int          m_mode  = 0;
   logic        m_full  = 1'b0;
   logic [15:0] m_buf   = '0;
   logic [15:0] m_cur   = '0;
   int          m_t     = 0;
   longint      m_total = 0;
   longint      m_nt    = 0;
   logic        m_pdm   = 1'b0;
   logic        m_ur    = 1'b0;
   logic        m_acc   = 1'b0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_mode = 0; m_full = 0; m_buf = 0; m_cur = 0;
         m_t = 0; m_total = 0; m_pdm = 0; m_ur = 0;
      end else begin
         m_acc = s_if.valid && enable && !m_full;
         m_ur  = 0;
         if (!enable) begin
            m_mode = 0; m_full = 0; m_pdm = 0; m_t = 0; m_total = 0;
         end else begin
            case (m_mode)
               0: m_mode = 1;
               1: if (m_full) begin
                     m_cur = m_buf; m_full = 0; m_t = 0; m_total = 0; m_mode = 2;
                  end
               default: begin
                  m_t++;
                  if (m_t % CLK_DIV == 0) begin
                     m_nt    = m_total + longint'(m_cur);
                     m_pdm   = ((m_nt >> WIDTH) != (m_total >> WIDTH));
                     m_total = m_nt;
                     if ((m_t / CLK_DIV) % BPS == 0) begin
                        if (m_full) begin
                           m_cur = m_buf; m_full = 0;
                        end else begin
                           m_ur = 1;
                        end
                     end
                  end
               end
            endcase
            if (m_acc) begin
               m_buf = s_if.data; m_full = 1;
            end
         end
      end
   end

   logic bitlog [512];
   int   hist_n = 0;
   int   ur_cnt = 0;

   always @(negedge clock) begin
      chk("pdm_o",      pdm_o,      m_pdm);
      chk("pdm_clk_o",  pdm_clk_o,  (m_mode == 2) && ((m_t % CLK_DIV) < CLK_DIV / 2));
      chk("audio_sd_o", audio_sd_o, m_mode != 0);
      chk("busy",       busy,       m_mode == 2);
      chk("underrun",   underrun,   m_ur);
      chk("ready",      s_if.ready, enable && !m_full);
      if (m_mode != 2) begin
         hist_n = 0;
         ur_cnt = 0;
      end else begin
         if (m_t > 0 && m_t % CLK_DIV == 0 && hist_n < 512) begin
            bitlog[hist_n] = pdm_o;
            hist_n++;
         end
         if (underrun) ur_cnt++;
      end
   end

   function automatic logic [15:0] pack(input int s);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[15-i] = bitlog[s+i];
      return r;
   endfunction

   function automatic int ones(input int s);
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(bitlog[s+i]);
      return n;
   endfunction

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic push(input logic [15:0] d);
      logic r;
      int   n;
      bit   got;
      n = 0; got = 0;
      s_if.data  = d;
      s_if.valid = 1'b1;
      while (!got && n < 2000) begin
         @(negedge clock);
         r = s_if.ready;
         @(posedge clock);
         got = r;
         n++;
      end
      #2;
      s_if.valid = 1'b0;
      chk("push_accepted", got, 1);
   endtask

   task automatic wait_bits(input int n);
      int c;
      c = 0;
      while (hist_n < n && c < 5000) begin
         step();
         c++;
      end
      chk("wait_bits", hist_n >= n, 1);
   endtask

   task automatic restart();
      enable = 1'b0;
      step();
      step();
      enable = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_n;
      logic r;
      s_if.valid = 1'b0;
      s_if.data  = '0;
      enable     = 1'b1;
      reset_n    = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_ready", s_if.ready, 1);
      chk("rst_pdm",   pdm_o,      0);
      chk("rst_sd",    audio_sd_o, 0);
      chk("rst_busy",  busy,       0);
      @(posedge clock);
      #2 reset_n = 1'b1;

      // mid-scale: alternating bits
      restart();
      push(16'h8000); push(16'h8000); push(16'h8000);
      wait_bits(32);
      chk("t1_first",  pack(0),  16'h5555);
      chk("t1_second", pack(16), 16'h5555);

      // full scale then zero
      restart();
      push(16'hFFFF); push(16'h0000);
      wait_bits(32);
      chk("t2_ffff", pack(0),  16'h7FFF);
      chk("t2_zero", pack(16), 16'h0000);

      // underrun repeats the last sample
      restart();
      push(16'h4000);
      wait_bits(17);
      chk("t3_ur_first", ur_cnt,  1);
      chk("t3_quarter",  pack(0), 16'h1111);
      push(16'h8000);
      wait_bits(47);
      chk("t3_no_ur", ur_cnt, 1);
      wait_bits(48);
      chk("t3_repeat", pack(16), 16'h1111);
      chk("t3_loaded", pack(32), 16'h5555);
      chk("t3_ur_end", ur_cnt,   2);

      // valid held high with stepping data
      restart();
      acc_n = 0;
      s_if.data  = 16'h0000;
      s_if.valid = 1'b1;
      for (int c = 0; c < 2000 && acc_n < 8; c++) begin
         @(negedge clock);
         r = s_if.ready;
         @(posedge clock);
         #2;
         if (r) begin
            acc_n++;
            s_if.data = s_if.data + 16'h1000;
         end
      end
      s_if.valid = 1'b0;
      chk("t4_accepts", acc_n, 8);
      wait_bits(128);
      for (int j = 0; j < 8; j++) chk("t4_ones", ones(16 * j), j);

      // enable dropped mid-sample
      restart();
      push(16'h8000); push(16'h8000);
      wait_bits(7);
      enable = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("t5_pdm",   pdm_o,      0);
      chk("t5_clk",   pdm_clk_o,  0);
      chk("t5_sd",    audio_sd_o, 0);
      chk("t5_busy",  busy,       0);
      chk("t5_ready", s_if.ready, 0);
      @(posedge clock);
      #2 enable = 1'b1;
      repeat (20) step();
      chk("t5_prime_busy", busy,       0);
      chk("t5_prime_sd",   audio_sd_o, 1);
      push(16'hFFFF);
      wait_bits(16);
      chk("t5_new_sample", pack(0), 16'h7FFF);

      // asynchronous reset between edges
      wait_bits(20);
      @(posedge clock);
      #3 reset_n = 1'b0;
      #1;
      chk("t6_sd",   audio_sd_o, 0);
      chk("t6_busy", busy,       0);
      chk("t6_clk",  pdm_clk_o,  0);
      chk("t6_pdm",  pdm_o,      0);
      @(posedge clock);
      #2 reset_n = 1'b1;
      step(); step();
      @(negedge clock);
      chk("t6_prime_sd",    audio_sd_o, 1);
      chk("t6_prime_busy",  busy,       0);
      chk("t6_prime_ready", s_if.ready, 1);

      // random traffic
      step();
      for (int i = 0; i < 3000; i++) begin
         s_if.valid = ($urandom_range(0, 3) == 0);
         s_if.data  = 16'($urandom);
         enable     = ($urandom_range(0, 299) != 0);
         step();
      end
      s_if.valid = 1'b0;
      enable     = 1'b1;
      repeat (10) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
